// File: rtl/game_scoreboard_if.sv
// game_scoreboard_if -- signal bundle between the guess FSM / board I/O and
// the scoreboard.
//   master : drives win, lose, clr; observes counts and display pins
//   slave  : the scoreboard itself
// Signals:
//   win, lose   level inputs from the guess FSM (high while in win/lose state)
//   clr         synchronous score clear (pre-debounced)
//   win_cnt     BCD win count {tens, units}
//   lose_cnt    BCD loss count {tens, units}
//   seg         active-low segments {g,f,e,d,c,b,a}
//   an          active-low digit anodes
//   dp          active-low decimal point
`timescale 1ns/1ps
interface game_scoreboard_if;
    logic       win;
    logic       lose;
    logic       clr;
    logic [7:0] win_cnt;
    logic [7:0] lose_cnt;
    logic [6:0] seg;
    logic [3:0] an;
    logic       dp;

    modport master (
        output win, lose, clr,
        input  win_cnt, lose_cnt, seg, an, dp
    );

    modport slave (
        input  win, lose, clr,
        output win_cnt, lose_cnt, seg, an, dp
    );
endinterface

// File: rtl/game_scoreboard.sv
// game_scoreboard -- BCD win/loss counters with a 4-digit multiplexed
// seven-segment display.
// Ports:
//   clk    system clock, all state on rising edge
//   reset  asynchronous active-high reset
//   bus    game_scoreboard_if.slave (win/lose/clr in; counts, seg/an/dp out)
// Parameters:
//   REFRESH_N  width of the free-running refresh counter (4..26); its top two
//              bits select the displayed digit
// Build option:
//   SCORE_SATURATE_EN  when defined, a counter at 99 holds instead of wrapping
//                      to 00
`timescale 1ns/1ps
module game_scoreboard #(
    parameter int unsigned REFRESH_N = 18
) (
    input  logic              clk,
    input  logic              reset,
    game_scoreboard_if.slave  bus
);

    localparam logic [REFRESH_N-1:0] REFRESH_ONE = REFRESH_N'(1);

    logic                 r_win_q;
    logic                 r_lose_q;
    logic [7:0]           r_win_cnt;
    logic [7:0]           r_lose_cnt;
    logic [REFRESH_N-1:0] r_refresh;
    logic [6:0]           r_seg;
    logic [3:0]           r_an;
    logic                 r_dp;

    logic                 w_win_edge;
    logic                 w_lose_edge;
    logic [1:0]           w_sel;
    logic [3:0]           w_digit;

    // One BCD step; non-BCD nibbles can never be produced from legal inputs.
    function automatic logic [7:0] bcd_inc(input logic [7:0] v);
        logic [7:0] n;
        n = v;
        if (v[3:0] == 4'd9) begin
            n[3:0] = 4'd0;
            n[7:4] = (v[7:4] == 4'd9) ? 4'd0 : v[7:4] + 4'd1;
        end else begin
            n[3:0] = v[3:0] + 4'd1;
        end
`ifdef SCORE_SATURATE_EN
        if (v == 8'h99) begin
            n = 8'h99;
        end
`endif
        return n;
    endfunction

    function automatic logic [6:0] seg7(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = 7'b1111111;
        endcase
        return s;
    endfunction

    assign w_win_edge  = bus.win  & ~r_win_q;
    assign w_lose_edge = bus.lose & ~r_lose_q;
    assign w_sel       = r_refresh[REFRESH_N-1 -: 2];

    // Digit order right-to-left: lose units, lose tens, win units, win tens.
    always_comb begin
        w_digit = '0;
        case (w_sel)
            2'd0: w_digit = r_lose_cnt[3:0];
            2'd1: w_digit = r_lose_cnt[7:4];
            2'd2: w_digit = r_win_cnt[3:0];
            2'd3: w_digit = r_win_cnt[7:4];
            default: w_digit = '0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_win_q    <= 1'b0;
            r_lose_q   <= 1'b0;
            r_win_cnt  <= '0;
            r_lose_cnt <= '0;
            r_refresh  <= '0;
            r_seg      <= '1;
            r_an       <= '1;
            r_dp       <= 1'b1;
        end else begin
            r_win_q   <= bus.win;
            r_lose_q  <= bus.lose;
            r_refresh <= r_refresh + REFRESH_ONE;

            // Clear beats any edge; coincident edges are ambiguous and dropped.
            if (bus.clr) begin
                r_win_cnt  <= '0;
                r_lose_cnt <= '0;
            end else if (w_win_edge && !w_lose_edge) begin
                r_win_cnt  <= bcd_inc(r_win_cnt);
            end else if (w_lose_edge && !w_win_edge) begin
                r_lose_cnt <= bcd_inc(r_lose_cnt);
            end

            r_an  <= ~(4'b0001 << w_sel);
            r_seg <= seg7(w_digit);
            // Decimal point between the win field and the loss field.
            r_dp  <= (w_sel != 2'd2);
        end
    end

    assign bus.win_cnt  = r_win_cnt;
    assign bus.lose_cnt = r_lose_cnt;
    assign bus.seg      = r_seg;
    assign bus.an       = r_an;
    assign bus.dp       = r_dp;

endmodule

// File: tb/tb_game_scoreboard.sv
// tb_game_scoreboard -- directed stimulus for game_scoreboard (REFRESH_N=4).
// Stimulus pushes expected responses, tagged with the cycle they are due, into
// a queue; a negedge monitor pops and compares them against the DUT.
`timescale 1ns/1ps
module tb_game_scoreboard;

    logic clk   = 1'b0;
    logic reset = 1'b0;

    game_scoreboard_if bus();

    game_scoreboard #(.REFRESH_N(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // kind 0: counts, 1: display pins, 2: everything (reset state)
    typedef struct {
        int unsigned due;
        int          kind;
        int          tag;
        logic [7:0]  w;
        logic [7:0]  l;
        logic [6:0]  seg;
        logic [3:0]  an;
        logic        dp;
    } exp_t;

    exp_t q[$];
    int checks = 0;
    int errors = 0;
    int unsigned rel0 = 0;
    logic [7:0] exp_w = 8'h00;
    logic [7:0] exp_l = 8'h00;

    localparam int T_RESET = 0, T_SWEEP = 1, T_WIN = 2, T_LOSE = 3, T_DISP = 4,
                   T_SIMUL = 5, T_CLR = 6, T_HOLD = 7, T_ASYNC = 8, T_WRAP = 9,
                   T_HAND = 10;

    function automatic string tname(input int t);
        case (t)
            T_RESET: return "reset_state";
            T_SWEEP: return "refresh_sweep";
            T_WIN:   return "win_count";
            T_LOSE:  return "lose_count";
            T_DISP:  return "digit_display";
            T_SIMUL: return "simultaneous_edges";
            T_CLR:   return "clear_priority";
            T_HOLD:  return "held_level";
            T_ASYNC: return "async_reset";
            T_WRAP:  return "boundary_99";
            default: return "fixed_value";
        endcase
    endfunction

    function automatic logic [7:0] bcd_inc(input logic [7:0] v);
`ifdef SCORE_SATURATE_EN
        if (v == 8'h99) return 8'h99;
`endif
        if (v == 8'h99) return 8'h00;
        if (v[3:0] == 4'd9) return {v[7:4] + 4'd1, 4'd0};
        return {v[7:4], v[3:0] + 4'd1};
    endfunction

    task automatic check_entry(input exp_t e);
        checks++;
        case (e.kind)
            0: if (bus.win_cnt !== e.w || bus.lose_cnt !== e.l) begin
                   errors++;
                   $display("FAIL %s cyc=%0d: win/lose=%h/%h required %h/%h",
                            tname(e.tag), cyc, bus.win_cnt, bus.lose_cnt, e.w, e.l);
               end
            1: if (bus.seg !== e.seg || bus.an !== e.an || bus.dp !== e.dp) begin
                   errors++;
                   $display("FAIL %s cyc=%0d: seg/an/dp=%b/%b/%b required %b/%b/%b",
                            tname(e.tag), cyc, bus.seg, bus.an, bus.dp, e.seg, e.an, e.dp);
               end
            default:
               if (bus.win_cnt !== e.w || bus.lose_cnt !== e.l || bus.seg !== e.seg ||
                   bus.an !== e.an || bus.dp !== e.dp) begin
                   errors++;
                   $display("FAIL %s cyc=%0d: cnt=%h/%h seg/an/dp=%b/%b/%b required %h/%h %b/%b/%b",
                            tname(e.tag), cyc, bus.win_cnt, bus.lose_cnt, bus.seg, bus.an,
                            bus.dp, e.w, e.l, e.seg, e.an, e.dp);
               end
        endcase
    endtask

    always @(negedge clk) begin
        for (int i = int'(q.size()) - 1; i >= 0; i--) begin
            if (q[i].due == cyc) begin
                check_entry(q[i]);
                q.delete(i);
            end else if (q[i].due < cyc) begin
                checks++;
                errors++;
                $display("FAIL %s: due cyc %0d never sampled, now %0d", tname(q[i].tag), q[i].due, cyc);
                q.delete(i);
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic push_cnt(input int tag, input int unsigned due, input logic [7:0] w, input logic [7:0] l);
        exp_t e;
        e.due = due; e.kind = 0; e.tag = tag; e.w = w; e.l = l;
        e.seg = '1; e.an = '1; e.dp = 1'b1;
        q.push_back(e);
    endtask

    task automatic push_pins(input int tag, input int unsigned due, input int unsigned sel, input logic [6:0] seg);
        exp_t e;
        e.due = due; e.kind = 1; e.tag = tag; e.w = '0; e.l = '0;
        e.seg = seg;
        e.an  = ~(4'b0001 << sel);
        e.dp  = (sel != 2);
        q.push_back(e);
    endtask

    // Next cycle (at least two ahead) whose registered outputs show digit sel.
    task automatic push_disp(input int tag, input int unsigned sel, input logic [6:0] seg);
        int unsigned c;
        c = cyc + 2;
        while ((((c - rel0) / 4) % 4) != sel) c++;
        push_pins(tag, c, sel, seg);
    endtask

    task automatic push_reset(input int tag);
        exp_t e;
        e.due = cyc; e.kind = 2; e.tag = tag; e.w = 8'h00; e.l = 8'h00;
        e.seg = 7'b1111111; e.an = 4'b1111; e.dp = 1'b1;
        q.push_back(e);
    endtask

    task automatic pulse(input bit is_win, input int hi, input int lo, input int tag);
        push_cnt(tag, cyc, exp_w, exp_l);
        if (is_win) begin
            bus.win = 1'b1;
            exp_w = bcd_inc(exp_w);
        end else begin
            bus.lose = 1'b1;
            exp_l = bcd_inc(exp_l);
        end
        push_cnt(tag, cyc + 1, exp_w, exp_l);
        step(hi);
        push_cnt(T_HOLD, cyc, exp_w, exp_l);
        bus.win  = 1'b0;
        bus.lose = 1'b0;
        step(lo);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        bus.win  = 1'b0;
        bus.lose = 1'b0;
        bus.clr  = 1'b0;
        #1 reset = 1'b1;
        step(1);
        push_reset(T_RESET);
        step(2);
        reset = 1'b0;
        rel0 = cyc + 1;

        // Digit scan with all-zero counts: 4 cycles per digit.
        for (int k = 0; k < 16; k++)
            push_pins(T_SWEEP, rel0 + k, (k / 4) % 4, 7'b1000000);
        step(18);

        // Three long win pulses.
        repeat (3) pulse(1'b1, 20, 20, T_WIN);
        push_cnt(T_HAND, cyc, 8'h03, 8'h00);
        push_disp(T_DISP, 2, 7'b0110000);
        step(20);

        // Nine losses, then the tens carry.
        repeat (9) pulse(1'b0, 2, 2, T_LOSE);
        push_cnt(T_HAND, cyc, 8'h03, 8'h09);
        push_disp(T_DISP, 0, 7'b0010000);
        step(20);
        pulse(1'b0, 2, 2, T_LOSE);
        push_cnt(T_HAND, cyc, 8'h03, 8'h10);
        push_disp(T_DISP, 1, 7'b1111001);
        push_disp(T_DISP, 0, 7'b1000000);
        push_disp(T_DISP, 3, 7'b1000000);
        step(20);

        // Coincident edges are discarded.
        bus.win  = 1'b1;
        bus.lose = 1'b1;
        push_cnt(T_SIMUL, cyc + 1, 8'h03, 8'h10);
        push_cnt(T_SIMUL, cyc + 3, 8'h03, 8'h10);
        step(3);
        bus.win  = 1'b0;
        bus.lose = 1'b0;
        step(2);

        // Clear wins over a win edge; edge register still sees the high level.
        bus.clr = 1'b1;
        bus.win = 1'b1;
        exp_w = 8'h00;
        exp_l = 8'h00;
        push_cnt(T_CLR, cyc + 1, 8'h00, 8'h00);
        step(1);
        bus.clr = 1'b0;
        step(2);
        push_cnt(T_CLR, cyc, 8'h00, 8'h00);
        bus.win = 1'b0;
        step(2);

        // Count to 42, then an asynchronous reset between edges.
        repeat (42) pulse(1'b1, 2, 2, T_WIN);
        push_cnt(T_HAND, cyc, 8'h42, 8'h00);
        step(1);
        reset = 1'b1;
        push_reset(T_ASYNC);
        bus.win = 1'b1;
        step(2);
        reset = 1'b0;
        rel0 = cyc + 1;
        exp_w = 8'h01;
        exp_l = 8'h00;
        push_cnt(T_ASYNC, cyc + 1, 8'h01, 8'h00);
        step(5);
        push_cnt(T_HOLD, cyc, 8'h01, 8'h00);
        bus.win = 1'b0;
        step(2);

        // 99 boundary.
        bus.clr = 1'b1;
        exp_w = 8'h00;
        exp_l = 8'h00;
        step(1);
        bus.clr = 1'b0;
        step(1);
        repeat (99) pulse(1'b1, 2, 2, T_WIN);
        push_cnt(T_HAND, cyc, 8'h99, 8'h00);
        pulse(1'b1, 2, 2, T_WRAP);
`ifdef SCORE_SATURATE_EN
        push_cnt(T_WRAP, cyc, 8'h99, 8'h00);
`else
        push_cnt(T_WRAP, cyc, 8'h00, 8'h00);
`endif
        pulse(1'b1, 2, 2, T_WRAP);
`ifdef SCORE_SATURATE_EN
        push_cnt(T_WRAP, cyc, 8'h99, 8'h00);
`else
        push_cnt(T_WRAP, cyc, 8'h01, 8'h00);
`endif
        step(4);

        foreach (q[i]) begin
            checks++;
            errors++;
            $display("FAIL %s: pending at end (due %0d)", tname(q[i].tag), q[i].due);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/game_scoreboard.md
GAME_SCOREBOARD -- requirements
Module: game_scoreboard

Interface
REQ-001 Parameter REFRESH_N, default 18, width of the free-running display refresh counter; legal range 4..26.
REQ-002 clk  input  1  system clock, 100 MHz board clock, all state on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset (driven from btnC).
REQ-004 win  input  1  level from guess FSM, high while FSM sits in its win state.
REQ-005 lose  input  1  level from guess FSM, high while FSM sits in its lose state.
REQ-006 clr  input  1  synchronous score clear, single-cycle or held; expected pre-debounced.
REQ-007 win_cnt  output  8  BCD win count {tens, units}, 00..99.
REQ-008 lose_cnt  output  8  BCD loss count {tens, units}, 00..99.
REQ-009 seg  output  7  active-low segments, bit order {g,f,e,d,c,b,a}.
REQ-010 an  output  4  active-low digit anodes, exactly one low outside reset.
REQ-011 dp  output  1  active-low decimal point.

Function
REQ-012 Block SHALL register win and lose each cycle (win_q, lose_q) and detect rising edges as win & ~win_q, lose & ~lose_q.
REQ-013 A win edge alone SHALL increment win_cnt by one BCD step on the following clock edge (1-cycle latency); lose edge likewise for lose_cnt.
REQ-014 A level held high for any number of cycles SHALL count exactly once.
REQ-015 BCD increment: units 9 -> 0 with tens +1; units 0..8 -> +1; counters never hold non-BCD nibbles.
REQ-016 Simultaneous win and lose edges in the same cycle SHALL be discarded; neither counter changes.
REQ-017 clr high SHALL zero both counters on the next edge and take priority over any edge in that cycle; edge registers still update.
REQ-018 Refresh counter SHALL increment every cycle, wrapping 2^REFRESH_N-1 -> 0; digit select = its top two bits.
REQ-019 Digit select 0 -> an=1110 shows lose units; 1 -> 1101 lose tens; 2 -> 1011 win units; 3 -> 0111 win tens.
REQ-020 Hex-to-segment decode for 0..9 standard (0 = 1000000, 1 = 1111001, 8 = 0000000); no leading-zero blanking.
REQ-021 dp SHALL be 0 only while digit select = 2 (separates win field from loss field), else 1.
REQ-022 seg, an, dp SHALL be registered: they reflect the digit select and count values present one cycle earlier.

Reset
REQ-023 reset high SHALL immediately force win_cnt=00, lose_cnt=00, win_q=0, lose_q=0, refresh counter=0, seg=1111111, an=1111, dp=1.
REQ-024 On the first edge after reset release, outputs SHALL show digit select 0 (an=1110, seg=1000000, dp=1).
REQ-025 Reset asserted mid-increment SHALL win; no partial count survives; win held high across release counts once (win_q resets to 0).

Configuration
REQ-026 Macro SCORE_SATURATE_EN: when defined, a counter at 99 SHALL hold 99 on further edges.
REQ-027 When SCORE_SATURATE_EN is undefined, a counter at 99 SHALL wrap to 00 on the next edge.
REQ-028 Macro affects only the 99 boundary; all other behaviour identical.

Verification
REQ-029 Reset, release, REFRESH_N=4 -> an cycles 1110,1101,1011,0111 every 4 cycles, seg=1000000 on each digit, dp=0 only with an=1011.
REQ-030 win high 20 cycles then low, repeated 3 times -> win_cnt=03, lose_cnt=00; each increment lands 1 cycle after the rising edge.
REQ-031 Preload via 9 lose pulses, then 1 more -> lose_cnt 09 -> 10; tens digit shows seg=1111001 at an=1101.
REQ-032 win and lose rise in same cycle -> both counts unchanged; clr asserted with a win edge in the same cycle -> win_cnt=00.
REQ-033 100 win pulses -> win_cnt=99 with SCORE_SATURATE_EN, 00 without; 101st pulse -> 99 / 01 respectively.
REQ-034 reset asserted asynchronously between clock edges with win_cnt=42 -> all outputs reach reset values before the next clock edge.
